ship_draw: RTL
==============

Name: ship_draw

Overview:
- Sprite-overlay stage that consumes the ship pixel ROM, the block generating the ROM's line address and receiving its 48-bit line.
- Sits in the VGA pixel pipeline after the background stage.
- Latches ship position once per frame, addresses the ROM, decodes 2-bit pixel codes to 12-bit RGB and overlays them on the incoming stream.
- Supports a hit-blink effect.

Parameters:
SHIP_W, 24, sprite width in pixels (48 bits / 2 bits per pixel)
SHIP_H, 32, sprite height in lines
ROM_BASE, 9'h040, ROM line address of sprite row 0
BLINK_FRAMES, 16, frames of blinking after a hit
COL_OUTLINE, 12'h222, colour for code 2'b01
COL_BODY, 12'h888, colour for code 2'b10
COL_HILITE, 12'hFFF, colour for code 2'b11

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hcount_in  in  11  horizontal pixel count
vcount_in  in  11  vertical line count
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing
rgb_in  in  12  background colour
xpos, ypos  in  11 each  requested top-left of ship
pos_valid  in  1  xpos/ypos valid this cycle
hit  in  1  single-cycle hit pulse
ship_line  out  9  ROM line address
figure_line_pixels  in  48  ROM data; registered, valid one cycle after ship_line
hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  delayed timing
rgb_out  out  12  composited colour
blinking  out  1  high while blink is active

Behaviour:
- Reset values: all outputs 0. ship_line = ROM_BASE. Pending and active position = 0. Blink counter = 0. Frame parity = 0.
- Latency: 3 cycles, input to output, for every timing signal and rgb.
- Stage 1 (reg): compute in_box, dy and dx.
  - in_box = (hcount_in ≥ x_act) && (hcount_in < x_act+SHIP_W) && (vcount_in ≥ y_act) && (vcount_in < y_act+SHIP_H).
  - Comparisons use 12-bit sums, so a ship at the right or bottom edge does not wrap.
  - dy = vcount_in − y_act, dx = hcount_in − x_act.
  - ship_line <= ROM_BASE + dy[4:0] when in_box, else ROM_BASE.
- Stage 2: ROM returns the line. Pipeline carries in_box and dx[4:0].
- Stage 3 (reg):
  - code = figure_line_pixels[47−2·dx −: 2]; column 0 is the MSBs.
  - Code 00 is transparent (rgb_in passes through); codes 01/10/11 map to COL_OUTLINE/COL_BODY/COL_HILITE.
  - Outside the box, or when hblnk or vblnk is set, rgb_in passes through.
- Position handshake:
  - pos_valid high loads xpos/ypos into the pending register; the last write wins.
  - The pending value copies to the active registers on the rising edge of vblnk_in (0→1).
  - If pos_valid and the vblnk rise coincide, the new xpos/ypos go straight to active.
  - Position never changes mid-frame.
- Blink FSM, states IDLE and BLINK:
  - hit in either state loads the counter with BLINK_FRAMES and enters BLINK; re-hit restarts the counter.
  - In BLINK, each vblnk rise decrements the counter and toggles parity. Counter reaching 0 returns to IDLE.
  - While parity = 1 in BLINK, the sprite is suppressed (treated as transparent).
  - blinking = (state == BLINK), registered.
  - hit on the same cycle as the final decrement: hit wins, and the state stays BLINK.
- Reset mid-frame: output returns to reset values immediately. The first frame after reset draws at (0,0) until a vblnk rise applies a pending position.

Optional Feature:
- Macro: SHIP_DRAW_FLIP_EN.
- When defined:
  - Adds input flip (1 bit), latched with position at the vblnk rise.
  - When the active flip is 1, column index becomes SHIP_W−1−dx; the ship is horizontally mirrored.
- When undefined:
  - The port is absent and no mirroring logic exists.

Decomposition:
- Shared package ship_pkg holds:
  - localparams SHIP_W, SHIP_H, ROM_BASE and the palette constants.
  - typedef vga_tim_t: packed struct of hcount, vcount, hsync, vsync, hblnk, vblnk.
  - typedef enum blink_state_t {IDLE, BLINK}.
- One natural sub-module: ship_blink_fsm, containing the counter, parity and state; ports are clk, rst_n, hit, vblnk_rise, hide and blinking.
- The pipeline and compositing stay in ship_draw.

Test Plan:
1. Reset, pos_valid with (100,50), one vblank, then scan line 50 → ship_line = 9'h040 at hcount 100..123. rgb_out equals the decoded ROM colours 3 cycles later; rgb_in passes through elsewhere.
2. pos_valid (200,80) mid-frame at vcount 300 → current frame is still drawn at the old position. The next frame draws at (200,80). A coincident pos_valid and vblnk rise applies the value immediately.
3. Position (1020,760) on a 1024×768 frame → only columns 1020..1023 and lines 760..767 are drawn, with no wrap to column 0 or line 0.
4. ROM code 00 over rgb_in 12'h0F0 → output 12'h0F0. Code 10 → 12'h888. Code 11 → 12'hFFF.
5. hit pulse → blinking = 1, and the ship is hidden on alternate frames for 16 frames, then blinking = 0. A re-hit at frame 10 extends the effect to 16 frames from the re-hit.
6. With SHIP_DRAW_FLIP_EN, flip = 1 → pixel at dx = 0 shows the ROM column 23 code. Assert rst_n low mid-line → all outputs are 0 asynchronously.

Source files
------------

// File: rtl/ship_pkg.sv
// Shared types, geometry and palette for the ship sprite overlay.
package ship_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned ROM_W   = 48;
    localparam int unsigned LINE_W  = 9;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned BLINK_W = 5;

    localparam int unsigned SHIP_W       = 24;
    localparam int unsigned SHIP_H       = 32;
    localparam int unsigned BLINK_FRAMES = 16;

    localparam logic [LINE_W-1:0] ROM_BASE    = 9'h040;
    localparam logic [RGB_W-1:0]  COL_OUTLINE = 12'h222;
    localparam logic [RGB_W-1:0]  COL_BODY    = 12'h888;
    localparam logic [RGB_W-1:0]  COL_HILITE  = 12'hFFF;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_tim_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_t;

    // Code 00 is transparent and returns the background colour.
    function automatic logic [RGB_W-1:0] code_to_rgb(input logic [1:0] code,
                                                     input logic [RGB_W-1:0] bg);
        logic [RGB_W-1:0] col;
        case (code)
            2'b01:   col = COL_OUTLINE;
            2'b10:   col = COL_BODY;
            2'b11:   col = COL_HILITE;
            default: col = bg;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/ship_blink_fsm.sv
// Hit-blink controller: counts frames after a hit and hides the ship on odd frames.
module ship_blink_fsm
    import ship_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic hit,
    input  logic vblnk_rise,
    output logic hide,
    output logic blinking
);

    blink_state_t       state_q, state_d;
    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               parity_q, parity_d;
    logic               hide_q, hide_d;
    logic               blinking_q, blinking_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            parity_q   <= 1'b0;
            hide_q     <= 1'b0;
            blinking_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            parity_q   <= parity_d;
            hide_q     <= hide_d;
            blinking_q <= blinking_d;
        end
    end

    // A hit always wins, including over the final decrement.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d  = BLINK;
                    cnt_d    = BLINK_W'(BLINK_FRAMES);
                    parity_d = 1'b0;
                end
            end
            BLINK: begin
                if (hit) begin
                    cnt_d    = BLINK_W'(BLINK_FRAMES);
                    parity_d = 1'b0;
                end else if (vblnk_rise) begin
                    cnt_d    = cnt_q - BLINK_W'(1);
                    parity_d = ~parity_q;
                    if (cnt_q == BLINK_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        blinking_d = (state_d == BLINK);
        hide_d     = (state_d == BLINK) && parity_d;
    end

    assign hide     = hide_q;
    assign blinking = blinking_q;

endmodule

// File: rtl/ship_draw.sv
// Ship sprite overlay: 3-stage pipeline addressing the ship ROM and compositing over rgb_in.
// Optional horizontal mirroring via input flip when SHIP_DRAW_FLIP_EN is defined.
module ship_draw
    import ship_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [CNT_W-1:0]  xpos,
    input  logic [CNT_W-1:0]  ypos,
    input  logic              pos_valid,
    input  logic              hit,
`ifdef SHIP_DRAW_FLIP_EN
    input  logic              flip,
`endif
    output logic [LINE_W-1:0] ship_line,
    input  logic [ROM_W-1:0]  figure_line_pixels,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              blinking
);

    vga_tim_t          tim_in, tim1_q, tim1_d, tim2_q, tim2_d, tim3_q, tim3_d;
    logic [RGB_W-1:0]  rgb1_q, rgb1_d, rgb2_q, rgb2_d, rgb3_q, rgb3_d;
    logic              in_box1_q, in_box1_d, in_box2_q, in_box2_d;
    logic [COL_W-1:0]  col1_q, col1_d, col2_q, col2_d;
    logic [LINE_W-1:0] ship_line_q, ship_line_d;
    logic [CNT_W-1:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [CNT_W-1:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic              vblnk_prev_q, vblnk_prev_d;
    logic              vblnk_rise, hide;
    logic [CNT_W:0]    h_ext, v_ext, x_ext, y_ext;
    logic [COL_W-1:0]  dx, dy;
    logic [5:0]        code_msb;
    logic [1:0]        code;
`ifdef SHIP_DRAW_FLIP_EN
    logic              pend_flip_q, pend_flip_d, act_flip_q, act_flip_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim1_q       <= '0;
            tim2_q       <= '0;
            tim3_q       <= '0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
            rgb3_q       <= '0;
            in_box1_q    <= 1'b0;
            in_box2_q    <= 1'b0;
            col1_q       <= '0;
            col2_q       <= '0;
            ship_line_q  <= ROM_BASE;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            vblnk_prev_q <= 1'b0;
`ifdef SHIP_DRAW_FLIP_EN
            pend_flip_q  <= 1'b0;
            act_flip_q   <= 1'b0;
`endif
        end else begin
            tim1_q       <= tim1_d;
            tim2_q       <= tim2_d;
            tim3_q       <= tim3_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
            rgb3_q       <= rgb3_d;
            in_box1_q    <= in_box1_d;
            in_box2_q    <= in_box2_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            ship_line_q  <= ship_line_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            vblnk_prev_q <= vblnk_prev_d;
`ifdef SHIP_DRAW_FLIP_EN
            pend_flip_q  <= pend_flip_d;
            act_flip_q   <= act_flip_d;
`endif
        end
    end

    // Position handshake: a write coinciding with the vblank rise bypasses the pending register.
    always_comb begin
        vblnk_prev_d = vblnk_in;
        vblnk_rise   = vblnk_in && !vblnk_prev_q;
        pend_x_d     = pos_valid ? xpos : pend_x_q;
        pend_y_d     = pos_valid ? ypos : pend_y_q;
        act_x_d      = vblnk_rise ? pend_x_d : act_x_q;
        act_y_d      = vblnk_rise ? pend_y_d : act_y_q;
`ifdef SHIP_DRAW_FLIP_EN
        pend_flip_d  = pos_valid ? flip : pend_flip_q;
        act_flip_d   = vblnk_rise ? pend_flip_d : act_flip_q;
`endif
    end

    // Stage 1: box test on one extra bit so edge positions never wrap.
    always_comb begin
        tim_in.hcount = hcount_in;
        tim_in.vcount = vcount_in;
        tim_in.hsync  = hsync_in;
        tim_in.vsync  = vsync_in;
        tim_in.hblnk  = hblnk_in;
        tim_in.vblnk  = vblnk_in;
        h_ext = {1'b0, hcount_in};
        v_ext = {1'b0, vcount_in};
        x_ext = {1'b0, act_x_q};
        y_ext = {1'b0, act_y_q};
        dx    = hcount_in[COL_W-1:0] - act_x_q[COL_W-1:0];
        dy    = vcount_in[COL_W-1:0] - act_y_q[COL_W-1:0];
        in_box1_d = (h_ext >= x_ext) && (h_ext < x_ext + (CNT_W+1)'(SHIP_W)) &&
                    (v_ext >= y_ext) && (v_ext < y_ext + (CNT_W+1)'(SHIP_H));
        col1_d = dx;
`ifdef SHIP_DRAW_FLIP_EN
        if (act_flip_q) begin
            col1_d = COL_W'(SHIP_W - 1) - dx;
        end
`endif
        ship_line_d = in_box1_d ? ROM_BASE + LINE_W'(dy) : ROM_BASE;
        tim1_d = tim_in;
        rgb1_d = rgb_in;
    end

    // Stage 2 waits on the ROM; stage 3 decodes and overlays.
    always_comb begin
        tim2_d    = tim1_q;
        rgb2_d    = rgb1_q;
        in_box2_d = in_box1_q;
        col2_d    = col1_q;
        code_msb  = 6'(ROM_W - 1) - {col2_q, 1'b0};
        code      = figure_line_pixels[code_msb -: 2];
        tim3_d    = tim2_q;
        rgb3_d    = rgb2_q;
        if (in_box2_q && !tim2_q.hblnk && !tim2_q.vblnk && !hide) begin
            rgb3_d = code_to_rgb(code, rgb2_q);
        end
    end

    ship_blink_fsm u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit        (hit),
        .vblnk_rise (vblnk_rise),
        .hide       (hide),
        .blinking   (blinking)
    );

    assign ship_line  = ship_line_q;
    assign hcount_out = tim3_q.hcount;
    assign vcount_out = tim3_q.vcount;
    assign hsync_out  = tim3_q.hsync;
    assign vsync_out  = tim3_q.vsync;
    assign hblnk_out  = tim3_q.hblnk;
    assign vblnk_out  = tim3_q.vblnk;
    assign rgb_out    = rgb3_q;

endmodule
